// File: rtl/input_skew_feeder_if.sv
// Bus bundle between the skew feeder, its upstream buffer and its controller.
// slave: feeder side (start/len/buffer data in; read strobe, lanes, status out).
interface input_skew_feeder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_ROWS   = 3,
  parameter int LEN_WIDTH  = 8
);
  logic                           i_start;
  logic [LEN_WIDTH-1:0]           i_len;
  logic                           o_buf_rd;
  logic [NUM_ROWS*DATA_WIDTH-1:0] i_buf_data;
  logic [NUM_ROWS*DATA_WIDTH-1:0] o_row_data;
  logic [NUM_ROWS-1:0]            o_row_valid;
  logic                           o_busy;
  logic                           o_done;

  modport master (
    output i_start, i_len, i_buf_data,
    input  o_buf_rd, o_row_data, o_row_valid,
    input  o_busy, o_done
  );

  modport slave (
    input  i_start, i_len, i_buf_data,
    output o_buf_rd, o_row_data, o_row_valid,
    output o_busy, o_done
  );
endinterface

// File: rtl/input_skew_feeder.sv
// Streams buffer words into a systolic array, delaying lane k by k cycles.
// Ports: i_clk, i_rst (sync, active-high), bus (slave modport of the bundle).
module input_skew_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_ROWS   = 3,
  parameter int LEN_WIDTH  = 8
) (
  input logic                 i_clk,
  input logic                 i_rst,
  input_skew_feeder_if.slave  bus
);
  localparam int DCW = $clog2(NUM_ROWS + 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [LEN_WIDTH-1:0] rd_left;
  logic [DCW-1:0]       drain_cnt;
  logic                 rd;
  logic                 cap_vld;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rd        = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.i_start) begin
          if (bus.i_len == '0) state_nxt = DONE;
          else                 state_nxt = READ;
        end
      end
      READ: begin
        rd = 1'b1;
        if (rd_left == LEN_WIDTH'(1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        // last element leaves lane NUM_ROWS-1 in the
        // NUM_ROWS+1-th drain cycle
        if (drain_cnt == DCW'(NUM_ROWS)) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_left   <= '0;
      drain_cnt <= '0;
      cap_vld   <= 1'b0;
    end else begin
      // buffer answers one cycle after the strobe
      cap_vld <= rd;
      if (state == IDLE && bus.i_start) begin
        rd_left <= bus.i_len;
      end else if (state == READ) begin
        rd_left <= rd_left - LEN_WIDTH'(1);
      end
      if (state == DRAIN) drain_cnt <= drain_cnt + DCW'(1);
      else                drain_cnt <= '0;
    end
  end

  assign bus.o_buf_rd = rd;
  assign bus.o_busy   = (state != IDLE);
  assign bus.o_done   = (state == DONE);

  for (genvar k = 0; k < NUM_ROWS; k++) begin : g_lane
    // lane k: capture stage plus k skew stages
    logic [DATA_WIDTH-1:0] sr [k+1];
    logic [k:0]            sv;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        sv <= '0;
        for (int j = 0; j <= k; j++) sr[j] <= '0;
      end else begin
        sv[0] <= cap_vld;
        // invalid slots carry zeros so the array sees padding
        sr[0] <= cap_vld ?
          bus.i_buf_data[k*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int j = 1; j <= k; j++) begin
          sv[j] <= sv[j-1];
          sr[j] <= sr[j-1];
        end
      end
    end

    assign bus.o_row_data[k*DATA_WIDTH +: DATA_WIDTH] = sr[k];
    assign bus.o_row_valid[k] = sv[k];
  end
endmodule
